regfile_tagged: RTL and testbench
=================================

REGFILE_TAGGED -- requirements
Module: regfile_tagged

Interface
REQ-001 Parameter DATA_W, default 32, meaning: register data width in bits.
REQ-002 Parameter ADDR_W, default 5, meaning: address width; DEPTH = 2**ADDR_W entries.
REQ-003 Parameter TAG_W, default 4, meaning: producer tag width for the busy scoreboard.
REQ-004 Parameter ZERO_REG, default 1, meaning: 1 = entry 0 hardwired to zero and never busy; 0 = entry 0 is ordinary.
REQ-005 Clocking: one clock; reset is synchronous and active-low. Ports are named clock and reset (reset low = reset asserted).
REQ-006 clock  input  1  sole clock; all state updates on its rising edge.
REQ-007 reset  input  1  synchronous active-low reset.
REQ-008 wr_en  input  1  commit write request.
REQ-009 wr_addr  input  ADDR_W  commit destination.
REQ-010 wr_data  input  DATA_W  commit data.
REQ-011 wr_tag  input  TAG_W  tag of the committing producer.
REQ-012 ts_en  input  1  dispatch request: mark the destination busy.
REQ-013 ts_addr  input  ADDR_W  register to mark busy.
REQ-014 ts_tag  input  TAG_W  new producer tag.
REQ-015 rd_addr1, rd_addr2  input  ADDR_W each  read addresses.
REQ-016 rd_data1, rd_data2  output  DATA_W each  read data.
REQ-017 rd_busy1, rd_busy2  output  1 each  the entry awaits a producer.
REQ-018 rd_tag1, rd_tag2  output  TAG_W each  pending producer tag; 0 when not busy.
REQ-019 init_done  output  1  high once the clear sweep has completed.

Function
REQ-020 State machine: INIT and RUN only. Reset forces INIT with sweep counter = 0. INIT moves to RUN when the counter reaches DEPTH-1.
REQ-021 INIT: each cycle clears data, busy and tag of entry[counter], then increments the counter; the sweep takes DEPTH cycles after reset deasserts.
REQ-022 INIT: wr_en and ts_en are ignored; all read outputs are driven 0.
REQ-023 init_done is 0 in reset and INIT, and 1 in RUN from the cycle after the last entry is cleared.
REQ-024 RUN, commit: wr_en writes wr_data to entry[wr_addr]. The busy bit clears only if the entry is busy and its stored tag equals wr_tag; otherwise the busy bit and tag are unchanged.
REQ-025 RUN, dispatch: ts_en sets busy = 1 and tag = ts_tag for entry[ts_addr], whatever its previous state.
REQ-026 Same-cycle commit and dispatch to the same address: the data is written and dispatch wins, so busy = 1 and tag = ts_tag.
REQ-027 Reads are combinational with a same-cycle commit bypass. If wr_en is high in RUN and wr_addr == rd_addrN, then:
  - rd_dataN = wr_data.
  - rd_busyN and rd_tagN reflect the post-commit state per REQ-024. The dispatch of REQ-025 is not bypassed.
REQ-028 With ZERO_REG = 1: writes and dispatches to entry 0 are ignored, and reads of entry 0 return data 0, busy 0, tag 0, including under bypass.
REQ-029 Both read ports are independent and may address the same entry; their outputs are then identical.
REQ-030 rd_tagN = 0 whenever rd_busyN = 0.
REQ-031 Storage is DEPTH x (DATA_W + 1 + TAG_W) bits. No width extension or truncation is applied to data.

Reset
REQ-032 While reset = 0 at a rising edge:
  - state = INIT, counter = 0, init_done = 0.
  - All read outputs = 0.
  - Array contents are defined only after the sweep completes.
REQ-033 Reset asserted mid-operation, in INIT or RUN, restarts the full sweep. No pending commit or dispatch from that cycle takes effect.

Verification
REQ-034 Init: release reset, default parameters -> init_done rises exactly 32 cycles later; every address reads data 0, busy 0.
REQ-035 Scoreboard:
  - Dispatch r5 with tag 3, then commit r5 with tag 2 and data 0xAAAA0000 -> data updated, busy 1, tag 3.
  - Then commit r5 with tag 3 and data 0x12345678 -> busy 0, tag 0, data 0x12345678.
REQ-036 Bypass: commit r7 with tag 0 while rd_addr1 = rd_addr2 = 7, with r7 busy under tag 0 -> same-cycle rd_data = wr_data, rd_busy = 0.
REQ-037 Collision: same-cycle commit r9 (tag 1, data 0x55) and dispatch r9 (tag 6) -> next cycle data 0x55, busy 1, tag 6.
REQ-038 Zero register: write 0xFFFFFFFF and dispatch to r0 -> reads of r0 give data 0, busy 0, tag 0. Repeat with ZERO_REG = 0 -> data 0xFFFFFFFF, busy 1.
REQ-039 Mid-sweep reset: assert reset at sweep cycle 10 for 1 cycle -> init_done stays 0 and rises 32 cycles after the release; writes during INIT leave no trace.

Source files
------------

// File: rtl/regfile_tagged.sv
// Register file with a per-entry busy/tag scoreboard, a post-reset clearing sweep
// and a same-cycle commit bypass on both combinational read ports.
module regfile_tagged #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int TAG_W    = 4,
  parameter int ZERO_REG = 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [TAG_W-1:0]  wr_tag,
  input  logic              ts_en,
  input  logic [ADDR_W-1:0] ts_addr,
  input  logic [TAG_W-1:0]  ts_tag,
  input  logic [ADDR_W-1:0] rd_addr1,
  input  logic [ADDR_W-1:0] rd_addr2,
  output logic [DATA_W-1:0] rd_data1,
  output logic [DATA_W-1:0] rd_data2,
  output logic              rd_busy1,
  output logic              rd_busy2,
  output logic [TAG_W-1:0]  rd_tag1,
  output logic [TAG_W-1:0]  rd_tag2,
  output logic              init_done
);

  localparam int DEPTH   = 2 ** ADDR_W;
  localparam int ENTRY_W = DATA_W + 1 + TAG_W;
  localparam logic [ADDR_W-1:0] LAST_IDX = {ADDR_W{1'b1}};
  localparam logic [ADDR_W-1:0] ZERO_IDX = {ADDR_W{1'b0}};

  typedef enum logic [0:0] {ST_INIT = 1'b0, ST_RUN = 1'b1} state_e;

  state_e            state_r;
  state_e            state_next_s;
  logic [ADDR_W-1:0] sweep_cnt_r;
  logic [DATA_W-1:0] data_r [DEPTH];
  logic              busy_r [DEPTH];
  logic [TAG_W-1:0]  tag_r  [DEPTH];
  logic              zero_reg_s;
  logic              run_s;
  logic              wr_ok_s;
  logic              ts_ok_s;

  assign zero_reg_s = (ZERO_REG != 0);
  assign run_s      = reset && (state_r == ST_RUN);

  // State register and sweep counter
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_r     <= ST_INIT;
      sweep_cnt_r <= ZERO_IDX;
    end else begin
      state_r <= state_next_s;
      if (state_r == ST_INIT) begin
        sweep_cnt_r <= sweep_cnt_r + ADDR_W'(1);
      end else begin
        sweep_cnt_r <= sweep_cnt_r;
      end
    end
  end

  // Next-state logic: leave INIT once the last entry has been cleared
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      ST_INIT: begin
        if (sweep_cnt_r == LAST_IDX) begin
          state_next_s = ST_RUN;
        end else begin
          state_next_s = ST_INIT;
        end
      end
      ST_RUN:  state_next_s = ST_RUN;
      default: state_next_s = ST_INIT;
    endcase
  end

  // Entry 0 swallows commits and dispatches when hardwired to zero
  always_comb begin
    wr_ok_s = wr_en && !(zero_reg_s && (wr_addr == ZERO_IDX));
    ts_ok_s = ts_en && !(zero_reg_s && (ts_addr == ZERO_IDX));
  end

  // Array update: clearing sweep in INIT, commit then dispatch in RUN (dispatch wins)
  always_ff @(posedge clock) begin
    if (reset && (state_r == ST_INIT)) begin
      data_r[sweep_cnt_r] <= {DATA_W{1'b0}};
      busy_r[sweep_cnt_r] <= 1'b0;
      tag_r[sweep_cnt_r]  <= {TAG_W{1'b0}};
    end else if (reset && (state_r == ST_RUN)) begin
      if (wr_ok_s) begin
        data_r[wr_addr] <= wr_data;
        if (busy_r[wr_addr] && (tag_r[wr_addr] == wr_tag)) begin
          busy_r[wr_addr] <= 1'b0;
          tag_r[wr_addr]  <= {TAG_W{1'b0}};
        end
      end
      if (ts_ok_s) begin
        busy_r[ts_addr] <= 1'b1;
        tag_r[ts_addr]  <= ts_tag;
      end
    end
  end

  function automatic logic [ENTRY_W-1:0] read_port(input logic [ADDR_W-1:0] addr);
    logic [DATA_W-1:0] d;
    logic              b;
    logic [TAG_W-1:0]  t;
    d = data_r[addr];
    b = busy_r[addr];
    t = tag_r[addr];
    // Bypass reflects the commit only; a same-cycle dispatch shows up next cycle
    if (run_s && wr_ok_s && (wr_addr == addr)) begin
      d = wr_data;
      if (b && (t == wr_tag)) begin
        b = 1'b0;
      end else begin
        b = b;
      end
    end else begin
      d = d;
    end
    if (!b) begin
      t = {TAG_W{1'b0}};
    end else begin
      t = t;
    end
    if (!run_s || (zero_reg_s && (addr == ZERO_IDX))) begin
      return {ENTRY_W{1'b0}};
    end else begin
      return {d, b, t};
    end
  endfunction

  // Output logic: init flag and both read ports
  always_comb begin
    init_done                      = run_s;
    {rd_data1, rd_busy1, rd_tag1}  = read_port(rd_addr1);
    {rd_data2, rd_busy2, rd_tag2}  = read_port(rd_addr2);
  end

endmodule

// File: tb/tb_regfile_tagged.sv
// Directed bench for regfile_tagged: one instance with ZERO_REG=1 and one with
// ZERO_REG=0 share the same stimulus.
module tb_regfile_tagged;

  logic        clock = 1'b0;
  logic        reset;
  logic        wr_en;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data;
  logic [3:0]  wr_tag;
  logic        ts_en;
  logic [4:0]  ts_addr;
  logic [3:0]  ts_tag;
  logic [4:0]  rd_addr1;
  logic [4:0]  rd_addr2;

  logic [31:0] rd_data1_a, rd_data2_a, rd_data1_b, rd_data2_b;
  logic        rd_busy1_a, rd_busy2_a, rd_busy1_b, rd_busy2_b;
  logic [3:0]  rd_tag1_a, rd_tag2_a, rd_tag1_b, rd_tag2_b;
  logic        init_done_a, init_done_b;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  regfile_tagged #(.DATA_W(32), .ADDR_W(5), .TAG_W(4), .ZERO_REG(1)) dut_a (
    .clock(clock), .reset(reset),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_tag(wr_tag),
    .ts_en(ts_en), .ts_addr(ts_addr), .ts_tag(ts_tag),
    .rd_addr1(rd_addr1), .rd_addr2(rd_addr2),
    .rd_data1(rd_data1_a), .rd_data2(rd_data2_a),
    .rd_busy1(rd_busy1_a), .rd_busy2(rd_busy2_a),
    .rd_tag1(rd_tag1_a), .rd_tag2(rd_tag2_a),
    .init_done(init_done_a)
  );

  regfile_tagged #(.DATA_W(32), .ADDR_W(5), .TAG_W(4), .ZERO_REG(0)) dut_b (
    .clock(clock), .reset(reset),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_tag(wr_tag),
    .ts_en(ts_en), .ts_addr(ts_addr), .ts_tag(ts_tag),
    .rd_addr1(rd_addr1), .rd_addr2(rd_addr2),
    .rd_data1(rd_data1_b), .rd_data2(rd_data2_b),
    .rd_busy1(rd_busy1_b), .rd_busy2(rd_busy2_b),
    .rd_tag1(rd_tag1_b), .rd_tag2(rd_tag2_b),
    .init_done(init_done_b)
  );

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
    end
  endtask

  // Sweep with commits/dispatches to 'wa' held for the first 20 INIT cycles.
  task automatic sweep(input logic [4:0] wa, input logic [31:0] wd, input bit mid_reset);
    int cycles;
    reset = 1'b1;
    wr_en = 1'b1; wr_addr = wa; wr_data = wd; wr_tag = 4'd9;
    ts_en = 1'b1; ts_addr = wa; ts_tag = 4'd9;
    rd_addr1 = wa; rd_addr2 = wa;
    if (mid_reset) begin
      repeat (10) step();
      chk("midsweep_done_before", {63'd0, init_done_a}, 64'd0);
      reset = 1'b0;
      step();
      chk("midsweep_done_in_reset", {63'd0, init_done_a}, 64'd0);
      reset = 1'b1;
    end
    cycles = 0;
    while (!init_done_a && cycles < 40) begin
      step();
      cycles++;
      if (cycles == 2) begin
        chk("init_rd_zero", {27'd0, rd_data1_a, rd_busy1_a, rd_tag1_a}, 64'd0);
      end
      if (cycles == 20) begin
        wr_en = 1'b0;
        ts_en = 1'b0;
      end
    end
    chk("init_cycles", 64'(cycles), 64'd32);
    chk("init_done_b", {63'd0, init_done_b}, 64'd1);
    chk("init_trace_data", {32'd0, rd_data1_b}, 64'd0);
    chk("init_trace_busy", {63'd0, rd_busy1_b}, 64'd0);
  endtask

  initial begin
    reset = 1'b0;
    wr_en = 1'b0; wr_addr = 5'd0; wr_data = 32'd0; wr_tag = 4'd0;
    ts_en = 1'b0; ts_addr = 5'd0; ts_tag = 4'd0;
    rd_addr1 = 5'd0; rd_addr2 = 5'd0;
    step();
    step();
    chk("reset_init_done", {63'd0, init_done_a}, 64'd0);
    chk("reset_rd1", {27'd0, rd_data1_a, rd_busy1_a, rd_tag1_a}, 64'd0);

    sweep(5'd3, 32'hDEAD_BEEF, 1'b0);

    for (int a = 0; a < 32; a++) begin
      rd_addr1 = 5'(a);
      rd_addr2 = 5'(31 - a);
      #1;
      chk("sweep_a_p1", {27'd0, rd_data1_a, rd_busy1_a, rd_tag1_a}, 64'd0);
      chk("sweep_a_p2", {27'd0, rd_data2_a, rd_busy2_a, rd_tag2_a}, 64'd0);
      chk("sweep_b_p1", {27'd0, rd_data1_b, rd_busy1_b, rd_tag1_b}, 64'd0);
      chk("sweep_b_p2", {27'd0, rd_data2_b, rd_busy2_b, rd_tag2_b}, 64'd0);
    end

    // Scoreboard: dispatch r5 tag 3, stale commit tag 2, matching commit tag 3
    ts_en = 1'b1; ts_addr = 5'd5; ts_tag = 4'd3;
    rd_addr1 = 5'd5; rd_addr2 = 5'd5;
    step();
    ts_en = 1'b0;
    chk("disp_r5", {27'd0, rd_data1_a, rd_busy1_a, rd_tag1_a}, {27'd0, 32'd0, 1'b1, 4'd3});
    wr_en = 1'b1; wr_addr = 5'd5; wr_tag = 4'd2; wr_data = 32'hAAAA_0000;
    #1;
    chk("stale_bypass", {27'd0, rd_data1_a, rd_busy1_a, rd_tag1_a}, {27'd0, 32'hAAAA_0000, 1'b1, 4'd3});
    step();
    wr_en = 1'b0;
    chk("stale_commit", {27'd0, rd_data1_a, rd_busy1_a, rd_tag1_a}, {27'd0, 32'hAAAA_0000, 1'b1, 4'd3});
    wr_en = 1'b1; wr_tag = 4'd3; wr_data = 32'h1234_5678;
    #1;
    chk("match_bypass", {27'd0, rd_data2_a, rd_busy2_a, rd_tag2_a}, {27'd0, 32'h1234_5678, 1'b0, 4'd0});
    step();
    wr_en = 1'b0;
    chk("match_commit", {27'd0, rd_data1_a, rd_busy1_a, rd_tag1_a}, {27'd0, 32'h1234_5678, 1'b0, 4'd0});

    // Bypass on both ports with tag 0
    ts_en = 1'b1; ts_addr = 5'd7; ts_tag = 4'd0;
    step();
    ts_en = 1'b0;
    rd_addr1 = 5'd7; rd_addr2 = 5'd7;
    wr_en = 1'b1; wr_addr = 5'd7; wr_tag = 4'd0; wr_data = 32'hCAFE_F00D;
    #1;
    chk("bypass_p1", {27'd0, rd_data1_a, rd_busy1_a, rd_tag1_a}, {27'd0, 32'hCAFE_F00D, 1'b0, 4'd0});
    chk("bypass_p2", {27'd0, rd_data2_a, rd_busy2_a, rd_tag2_a}, {27'd0, 32'hCAFE_F00D, 1'b0, 4'd0});
    step();
    wr_en = 1'b0;

    // Commit/dispatch collision on r9
    rd_addr1 = 5'd9; rd_addr2 = 5'd9;
    wr_en = 1'b1; wr_addr = 5'd9; wr_tag = 4'd1; wr_data = 32'h0000_0055;
    ts_en = 1'b1; ts_addr = 5'd9; ts_tag = 4'd6;
    #1;
    chk("collide_bypass", {27'd0, rd_data1_a, rd_busy1_a, rd_tag1_a}, {27'd0, 32'h55, 1'b0, 4'd0});
    step();
    wr_en = 1'b0; ts_en = 1'b0;
    chk("collide_after", {27'd0, rd_data1_a, rd_busy1_a, rd_tag1_a}, {27'd0, 32'h55, 1'b1, 4'd6});

    // Zero register vs ordinary entry 0
    rd_addr1 = 5'd0; rd_addr2 = 5'd0;
    wr_en = 1'b1; wr_addr = 5'd0; wr_tag = 4'd0; wr_data = 32'hFFFF_FFFF;
    ts_en = 1'b1; ts_addr = 5'd0; ts_tag = 4'd5;
    #1;
    chk("r0_bypass_a", {27'd0, rd_data1_a, rd_busy1_a, rd_tag1_a}, 64'd0);
    chk("r0_bypass_b", {27'd0, rd_data1_b, rd_busy1_b, rd_tag1_b}, {27'd0, 32'hFFFF_FFFF, 1'b0, 4'd0});
    step();
    wr_en = 1'b0; ts_en = 1'b0;
    chk("r0_after_a", {27'd0, rd_data2_a, rd_busy2_a, rd_tag2_a}, 64'd0);
    chk("r0_after_b", {27'd0, rd_data2_b, rd_busy2_b, rd_tag2_b}, {27'd0, 32'hFFFF_FFFF, 1'b1, 4'd5});

    // Reset from RUN, then a sweep interrupted at cycle 10
    rd_addr1 = 5'd5;
    reset = 1'b0;
    step();
    chk("run_reset_done", {63'd0, init_done_a}, 64'd0);
    chk("run_reset_rd", {27'd0, rd_data1_a, rd_busy1_a, rd_tag1_a}, 64'd0);
    sweep(5'd12, 32'h0000_0077, 1'b1);
    rd_addr1 = 5'd5; rd_addr2 = 5'd9;
    #1;
    chk("post_r5", {27'd0, rd_data1_a, rd_busy1_a, rd_tag1_a}, 64'd0);
    chk("post_r9", {27'd0, rd_data2_a, rd_busy2_a, rd_tag2_a}, 64'd0);
    rd_addr1 = 5'd12; rd_addr2 = 5'd0;
    #1;
    chk("post_r12", {27'd0, rd_data1_a, rd_busy1_a, rd_tag1_a}, 64'd0);
    chk("post_r0_b", {27'd0, rd_data2_b, rd_busy2_b, rd_tag2_b}, 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
